// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_param_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// o_done marks the cycle whose step completes the product on o_prod.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_x,
    input  logic [WIDTH-1:0]   i_y,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_cnt    <= CW'(WIDTH);
            r_mcand  <= {{WIDTH{1'b0}}, i_x};
            r_mplier <= i_y;
            r_acc    <= '0;
        end else if (r_cnt != '0) begin
            r_cnt    <= r_cnt - CW'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
        end
    end

    // Product is taken from the adder so the top can register it on the last step.
    assign o_done = (r_cnt == CW'(1));
    assign o_prod = w_acc_next;

endmodule

// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready handshake and registered flags.
// ALU_SEQ_MUL_EN enables the iterative multiply for op 111.
module alu_seq_param
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             S,
    output logic             ZR,
    output logic             CY,
    output logic             P,
    output logic             V,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic [WIDTH-1:0] r_z;
    logic             r_s, r_zr, r_cy, r_p, r_v;

    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_add, w_sub, w_shl, w_shr;
    logic [WIDTH-1:0] w_alu_z, w_res_z;
    logic             w_alu_cy, w_alu_v, w_res_cy, w_res_v;

    assign w_amt = Y[SHW-1:0];
    assign w_add = {1'b0, X} + {1'b0, Y};
    assign w_sub = {1'b0, X} - {1'b0, Y};
    assign w_shl = {1'b0, X} << w_amt;
    // Extra low bit catches the last bit shifted out on a right shift.
    assign w_shr = {X, 1'b0} >> w_amt;

    always_comb begin
        w_alu_z  = '0;
        w_alu_cy = 1'b0;
        w_alu_v  = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_z  = w_add[WIDTH-1:0];
                w_alu_cy = w_add[WIDTH];
                w_alu_v  = (X[WIDTH-1] == Y[WIDTH-1]) &&
                           (w_add[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_z  = w_sub[WIDTH-1:0];
                w_alu_cy = w_sub[WIDTH];
                w_alu_v  = (X[WIDTH-1] != Y[WIDTH-1]) &&
                           (w_sub[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND:  w_alu_z = X & Y;
            OP_OR:   w_alu_z = X | Y;
            OP_XOR:  w_alu_z = X ^ Y;
            OP_SHL: begin
                w_alu_z  = w_shl[WIDTH-1:0];
                w_alu_cy = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_z  = w_shr[WIDTH:1];
                w_alu_cy = w_shr[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_prod;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mul_start),
        .i_x     (X),
        .i_y     (Y),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    assign w_res_z  = (r_state == ST_MUL) ? w_prod[WIDTH-1:0] : w_alu_z;
    assign w_res_cy = (r_state == ST_MUL) ? (|w_prod[2*WIDTH-1:WIDTH]) : w_alu_cy;
    assign w_res_v  = (r_state == ST_MUL) ? 1'b0 : w_alu_v;
    assign busy     = (r_state == ST_MUL);
`else
    assign w_res_z  = w_alu_z;
    assign w_res_cy = w_alu_cy;
    assign w_res_v  = w_alu_v;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_mul_start = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        w_next      = ST_MUL;
                        w_mul_start = 1'b1;
                    end else
`endif
                    begin
                        w_next = ST_HOLD;
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                if (w_mul_done) begin
                    w_next = ST_HOLD;
                    w_load = 1'b1;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            ST_HOLD: begin
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z  <= '0;
            r_s  <= 1'b0;
            r_zr <= 1'b0;
            r_cy <= 1'b0;
            r_p  <= 1'b0;
            r_v  <= 1'b0;
        end else if (w_load) begin
            r_z  <= w_res_z;
            r_s  <= w_res_z[WIDTH-1];
            r_zr <= (w_res_z == '0);
            r_cy <= w_res_cy;
            r_p  <= ~^w_res_z;
            r_v  <= w_res_v;
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_HOLD);
    assign Z  = r_z;
    assign S  = r_s;
    assign ZR = r_zr;
    assign CY = r_cy;
    assign P  = r_p;
    assign V  = r_v;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=16) with a transaction-level model.
// Follows ALU_SEQ_MUL_EN the same way the RTL does.
module tb_alu_seq_param;

    localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [2:0] op;
    logic [W-1:0] X, Y, Z;
    logic in_ready, out_valid, S, ZR, CY, P, V, busy;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .S(S), .ZR(ZR), .CY(CY), .P(P), .V(V), .busy(busy)
    );

    int n_checks = 0;
    int n_err = 0;

    logic chk_en = 1'b0;
    logic e_in_ready, e_busy, e_out_valid, e_cmp_z;
    logic [W-1:0] e_z;
    logic [4:0] e_f;
    logic [W-1:0] got_z;
    logic [4:0] got_f;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] x, y, z;
        logic [4:0]   f;
        int           hold;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {Z, S, ZR, CY, P, V} straight from the arithmetic meaning of each op.
    function automatic logic [W+4:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        int sx, sy, r, a;
        int unsigned u;
        logic [W-1:0] z;
        logic cy, v;
        sx = int'($signed(x));
        sy = int'($signed(y));
        a  = int'(y[3:0]);
        z = '0; cy = 1'b0; v = 1'b0; u = 0; r = 0;
        case (o)
            3'd0: begin
                u = 32'(x) + 32'(y);
                z = u[W-1:0];
                cy = (u > 32'hffff);
                r = sx + sy;
                v = (r > 32767) || (r < -32768);
            end
            3'd1: begin
                z = x - y;
                cy = (x < y);
                r = sx - sy;
                v = (r > 32767) || (r < -32768);
            end
            3'd2: z = x & y;
            3'd3: z = x | y;
            3'd4: z = x ^ y;
            3'd5: begin
                z = x << a;
                cy = (a != 0) && x[W-a];
            end
            3'd6: begin
                z = x >> a;
                cy = (a != 0) && x[a-1];
            end
            default: begin
                if (MUL_EN) begin
                    u = 32'(x) * 32'(y);
                    z = u[W-1:0];
                    cy = ((u >> 16) != 0);
                end
            end
        endcase
        return {z, z[W-1], z == '0, cy, ($countones(z) % 2) == 0, v};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(e_in_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("out_valid", 32'(out_valid), 32'(e_out_valid));
            if (e_out_valid || e_cmp_z) begin
                chk("Z", 32'(Z), 32'(e_z));
                chk("flags", 32'({S, ZR, CY, P, V}), 32'(e_f));
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        logic [W+4:0] m;
        int lat;
        m = model(o, x, y);
        lat = (MUL_EN && o == 3'd7) ? W + 1 : 1;
        in_valid = 1'b1; op = o; X = x; Y = y;
        e_in_ready = 1'b1; e_busy = 1'b0; e_out_valid = 1'b0; e_cmp_z = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c < lat; c++) begin
            e_in_ready = 1'b0; e_busy = 1'b1; e_out_valid = 1'b0;
            in_valid = 1'b1; X = W'($urandom); Y = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        e_in_ready = 1'b0; e_busy = 1'b0; e_out_valid = 1'b1;
        e_z = m[W+4:5]; e_f = m[4:0];
        for (int c = 0; c < hold; c++) begin
            out_ready = 1'b0; in_valid = 1'b1; X = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        got_z = Z;
        got_f = {S, ZR, CY, P, V};
        @(posedge clk); #1;
        out_ready = 1'b0;
        e_out_valid = 1'b0; e_in_ready = 1'b1;
    endtask

    task automatic reset_mid(input logic [2:0] o);
        logic [W+4:0] m;
        bool_mul: begin end
        m = model(o, 16'h0100, 16'h0100);
        in_valid = 1'b1; op = o; X = 16'h0100; Y = 16'h0100;
        e_in_ready = 1'b1; e_busy = 1'b0; e_out_valid = 1'b0; e_cmp_z = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e_in_ready = 1'b0;
        e_busy = MUL_EN && (o == 3'd7);
        e_out_valid = !e_busy;
        e_z = m[W+4:5]; e_f = m[4:0];
        repeat (4) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mid_Z", 32'(Z), 32'd0);
        chk("rst_mid_flags", 32'({S, ZR, CY, P, V}), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
        e_in_ready = 1'b1; e_busy = 1'b0; e_out_valid = 1'b0;
        e_cmp_z = 1'b1; e_z = '0; e_f = '0;
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; X = '0; Y = '0;
        e_in_ready = 1'b0; e_busy = 1'b0; e_out_valid = 1'b0;
        e_cmp_z = 1'b1; e_z = '0; e_f = '0;
        got_z = '0; got_f = '0;
        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_Z", 32'(Z), 32'd0);
        chk("reset_flags", 32'({S, ZR, CY, P, V}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        e_in_ready = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        vq.push_back('{3'd0, 16'h8fff, 16'h8000, 16'h0fff, 5'b00111, 0});
        vq.push_back('{3'd1, 16'hfffe, 16'h0002, 16'hfffc, 5'b10010, 1});
        vq.push_back('{3'd1, 16'h0001, 16'h0002, 16'hffff, 5'b10110, 0});
        vq.push_back('{3'd4, 16'haaaa, 16'h5555, 16'hffff, 5'b10010, 0});
        vq.push_back('{3'd5, 16'h8001, 16'h0001, 16'h0002, 5'b00100, 0});
        vq.push_back('{3'd7, 16'h0100, 16'h0100, 16'h0000,
                       MUL_EN ? 5'b01110 : 5'b01010, 2});
        vq.push_back('{3'd0, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 3});
        vq.push_back('{3'd2, 16'hf0f0, 16'h3c3c, 16'h3030, 5'b00010, 0});
        vq.push_back('{3'd3, 16'h0f00, 16'h00f0, 16'h0ff0, 5'b00010, 0});
        vq.push_back('{3'd6, 16'h8001, 16'h0004, 16'h0800, 5'b00000, 0});
        vq.push_back('{3'd6, 16'h000f, 16'h0013, 16'h0001, 5'b00100, 0});
        vq.push_back('{3'd5, 16'h1234, 16'h0010, 16'h1234, 5'b00000, 0});
        vq.push_back('{3'd0, 16'h7fff, 16'h0001, 16'h8000, 5'b10001, 0});
        vq.push_back('{3'd1, 16'h8000, 16'h0001, 16'h7fff, 5'b00001, 0});
        vq.push_back('{3'd0, 16'hffff, 16'h0001, 16'h0000, 5'b01110, 0});
        vq.push_back('{3'd7, 16'h0003, 16'h0005, MUL_EN ? 16'h000f : 16'h0000,
                       MUL_EN ? 5'b00010 : 5'b01010, 0});

        foreach (vq[i]) begin
            chk($sformatf("vec%0d_model", i),
                32'(model(vq[i].op, vq[i].x, vq[i].y)), 32'({vq[i].z, vq[i].f}));
            run_op(vq[i].op, vq[i].x, vq[i].y, vq[i].hold);
            chk($sformatf("vec%0d_Z", i), 32'(got_z), 32'(vq[i].z));
            chk($sformatf("vec%0d_flags", i), 32'(got_f), 32'(vq[i].f));
        end

        reset_mid(MUL_EN ? 3'd7 : 3'd0);
        run_op(3'd7, 16'h0003, 16'h0005, 0);
        chk("post_rst_mul_Z", 32'(got_z), MUL_EN ? 32'h000f : 32'h0000);
        run_op(3'd0, 16'h1234, 16'h1111, 1);
        chk("post_rst_add_Z", 32'(got_z), 32'h2345);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
